// File: rtl/firmware_arbiter_if.sv
// Bundle of the CPU read port, debug readback port and firmware ROM port.
// Ports: cpu_* (6502 read strobe/RDY/data), dbg_* (level request, ack/error/data),
//        rom_* (14-bit address, region selects, combinational read data).
interface firmware_arbiter_if;
  logic        cpu_req;
  logic [15:0] cpu_address;
  logic        cpu_ready;
  logic        cpu_valid;
  logic [7:0]  cpu_data;

  logic        dbg_req;
  logic [15:0] dbg_address;
  logic        dbg_ack;
  logic        dbg_error;
  logic [7:0]  dbg_data;

  logic [13:0] rom_address;
  logic [7:0]  rom_data;
  logic        rom_select_firmware;
  logic        rom_select_vectors;

  // Arbiter side: takes requests and ROM data, drives results and the ROM port.
  modport slave (
    input  cpu_req, cpu_address, dbg_req, dbg_address, rom_data,
    output cpu_ready, cpu_valid, cpu_data,
    output dbg_ack, dbg_error, dbg_data,
    output rom_address, rom_select_firmware, rom_select_vectors
  );

  // Requester/ROM side: the mirror image.
  modport master (
    output cpu_req, cpu_address, dbg_req, dbg_address, rom_data,
    input  cpu_ready, cpu_valid, cpu_data,
    input  dbg_ack, dbg_error, dbg_data,
    input  rom_address, rom_select_firmware, rom_select_vectors
  );
endinterface

// File: rtl/firmware_arbiter.sv
// Shares the firmware ROM between the 6502 bus (priority) and the debug readback port.
// Latency: grant edge E0 drives the ROM, E1 captures; valid/ack high in the cycle after E1.
// Backpressure: CPU is stalled one cycle via cpu_ready after STARVE_LIMIT wins over a waiting debug read.
// Ports: clk, rst (sync, active-high), bus (firmware_arbiter_if.slave: cpu_*, dbg_*, rom_*).
module firmware_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  firmware_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT     = 8'(STARVE_LIMIT);
  localparam logic       OWNER_CPU = 1'b0;
  localparam logic       OWNER_DBG = 1'b1;

  // Arbitration / starvation state
  logic [7:0]  starve_count;
  logic        dbg_busy;
  logic        cpu_ready_q;

  // Stage A (ROM drive) registers
  logic        a_vld;
  logic        a_owner;
  logic        a_miss;
  logic [13:0] rom_address_q;
  logic        sel_fw_q;
  logic        sel_vec_q;

  // Stage B (result) registers
  logic        cpu_valid_q;
  logic [7:0]  cpu_data_q;
  logic        dbg_ack_q;
  logic        dbg_error_q;
  logic [7:0]  dbg_data_q;

  // Combinational arbitration and decode
  logic        dbg_pending;
  logic        cpu_win;
  logic        dbg_win;
  logic [15:0] win_address;
  logic        win_hit;
  logic        win_vec;
  logic [7:0]  starve_next;

  always_comb begin
    dbg_pending = bus.dbg_req && !dbg_busy;
    // A stalled cycle (cpu_ready_q=0) blocks the CPU, so the debug port
    // takes the slot; its request is still pending because dbg_req is a level.
    cpu_win     = bus.cpu_req && cpu_ready_q;
    dbg_win     = !cpu_win && dbg_pending;
    win_address = cpu_win ? bus.cpu_address : bus.dbg_address;
    win_hit     = (win_address[15:14] == 2'b11);
    win_vec     = (win_address >= 16'hFFFA);
    starve_next = starve_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_count  <= '0;
      dbg_busy      <= 1'b0;
      cpu_ready_q   <= 1'b1;
      a_vld         <= 1'b0;
      a_owner       <= OWNER_CPU;
      a_miss        <= 1'b0;
      rom_address_q <= '0;
      sel_fw_q      <= 1'b0;
      sel_vec_q     <= 1'b0;
      cpu_valid_q   <= 1'b0;
      cpu_data_q    <= '0;
      dbg_ack_q     <= 1'b0;
      dbg_error_q   <= 1'b0;
      dbg_data_q    <= '0;
    end else begin
      // Starvation counter: a stall is only ever one cycle long because the
      // stalled cycle always grants the debug port, which clears the count.
      cpu_ready_q <= 1'b1;
      if (cpu_win && dbg_pending) begin
        starve_count <= starve_next;
        if (starve_next == LIMIT) begin
          cpu_ready_q <= 1'b0;
        end
      end else begin
        starve_count <= '0;
      end

      // A debug read stays owned from grant until the edge closing its ack cycle,
      // so a level dbg_req held through the ack does not start a second read.
      if (dbg_win) begin
        dbg_busy <= 1'b1;
      end else if (dbg_ack_q) begin
        dbg_busy <= 1'b0;
      end

      // Stage A: drive the winner's decode onto the ROM port
      a_vld   <= cpu_win || dbg_win;
      a_owner <= dbg_win ? OWNER_DBG : OWNER_CPU;
      if (cpu_win || dbg_win) begin
        a_miss        <= !win_hit;
        rom_address_q <= win_hit ? win_address[13:0] : 14'd0;
        sel_vec_q     <= win_hit && win_vec;
        sel_fw_q      <= win_hit && !win_vec;
      end else begin
        // Idle: deselect the ROM, leave the address where it was
        sel_vec_q <= 1'b0;
        sel_fw_q  <= 1'b0;
      end

      // Stage B: capture ROM data for the owner and pulse its strobe
      cpu_valid_q <= a_vld && (a_owner == OWNER_CPU);
      dbg_ack_q   <= a_vld && (a_owner == OWNER_DBG);
      if (a_vld && (a_owner == OWNER_CPU)) begin
        cpu_data_q <= a_miss ? 8'h00 : bus.rom_data;
      end
      if (a_vld && (a_owner == OWNER_DBG)) begin
        dbg_data_q  <= a_miss ? 8'h00 : bus.rom_data;
        dbg_error_q <= a_miss;
      end
    end
  end

  assign bus.cpu_ready           = cpu_ready_q;
  assign bus.cpu_valid           = cpu_valid_q;
  assign bus.cpu_data            = cpu_data_q;
  assign bus.dbg_ack             = dbg_ack_q;
  assign bus.dbg_error           = dbg_error_q;
  assign bus.dbg_data            = dbg_data_q;
  assign bus.rom_address         = rom_address_q;
  assign bus.rom_select_firmware = sel_fw_q;
  assign bus.rom_select_vectors  = sel_vec_q;

endmodule

// File: tb/tb_firmware_arbiter.sv
// Bench for firmware_arbiter: directed vectors plus a bounded random interleave.
// ROM model returns address[7:0]^0x5A; outputs are sampled 1 time unit after each edge.
// Ports: drives the interface master side, clk and rst.
module tb_firmware_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  firmware_arbiter_if bus();

  firmware_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational ROM model
  assign bus.rom_data = bus.rom_address[7:0] ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_data(input logic [15:0] a);
    return (a[15:14] == 2'b11) ? (a[7:0] ^ 8'h5A) : 8'h00;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       a = a;
      1:       a = 16'hFFF8 | 16'($urandom_range(0, 7));
      default: a[15:14] = 2'b11;
    endcase
    return a;
  endfunction

  initial begin
    int          n_valid;
    logic        cpu_acc;
    logic [15:0] cpu_acc_addr;
    logic        dbg_out;
    logic [15:0] dbg_addr;
    int          dbg_wait;
    logic        prev_low;
    logic [7:0]  cpu_q[$];
    int          due_q[$];
    logic [7:0]  e;
    int          due;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.cpu_req     = 1'b0;
    bus.cpu_address = 16'h0000;
    bus.dbg_req     = 1'b0;
    bus.dbg_address = 16'h0000;
    step();
    step();

    // Reset state
    chk("rst_cpu_ready", bus.cpu_ready, 1);
    chk("rst_cpu_valid", bus.cpu_valid, 0);
    chk("rst_cpu_data", bus.cpu_data, 0);
    chk("rst_dbg_ack", bus.dbg_ack, 0);
    chk("rst_dbg_error", bus.dbg_error, 0);
    chk("rst_dbg_data", bus.dbg_data, 0);
    chk("rst_rom_address", bus.rom_address, 0);
    chk("rst_sel_fw", bus.rom_select_firmware, 0);
    chk("rst_sel_vec", bus.rom_select_vectors, 0);
    rst = 1'b0;
    step();

    // CPU reads: firmware region then vector region, back to back
    bus.cpu_req = 1'b1;
    bus.cpu_address = 16'hC010;
    step();
    chk("cpu1_sel_fw", bus.rom_select_firmware, 1);
    chk("cpu1_sel_vec", bus.rom_select_vectors, 0);
    chk("cpu1_rom_addr", bus.rom_address, 14'h0010);
    chk("cpu1_valid_early", bus.cpu_valid, 0);
    bus.cpu_address = 16'hFFFC;
    step();
    chk("cpu1_valid", bus.cpu_valid, 1);
    chk("cpu1_data", bus.cpu_data, 8'h4A);
    chk("cpu2_sel_vec", bus.rom_select_vectors, 1);
    chk("cpu2_sel_fw", bus.rom_select_firmware, 0);
    chk("cpu2_rom_addr", bus.rom_address, 14'h3FFC);
    bus.cpu_req = 1'b0;
    step();
    chk("cpu2_valid", bus.cpu_valid, 1);
    chk("cpu2_data", bus.cpu_data, 8'hA6);
    chk("idle_sel_vec", bus.rom_select_vectors, 0);
    chk("idle_rom_hold", bus.rom_address, 14'h3FFC);
    step();
    chk("cpu_valid_pulse", bus.cpu_valid, 0);
    chk("cpu_data_hold", bus.cpu_data, 8'hA6);

    // Debug read with CPU idle; dbg_req held through the ack cycle
    bus.dbg_req = 1'b1;
    bus.dbg_address = 16'hFFFA;
    step();
    chk("dbg1_sel_vec", bus.rom_select_vectors, 1);
    chk("dbg1_rom_addr", bus.rom_address, 14'h3FFA);
    chk("dbg1_cpu_ready", bus.cpu_ready, 1);
    chk("dbg1_ack_early", bus.dbg_ack, 0);
    step();
    chk("dbg1_ack", bus.dbg_ack, 1);
    chk("dbg1_data", bus.dbg_data, 8'hA0);
    chk("dbg1_error", bus.dbg_error, 0);
    chk("dbg1_busy_no_grant", bus.rom_select_vectors, 0);
    step();
    chk("dbg1_ack_pulse", bus.dbg_ack, 0);
    chk("dbg1_no_regrant", bus.rom_select_vectors, 0);
    bus.dbg_req = 1'b0;
    step();
    chk("dbg1_no_second_ack", bus.dbg_ack, 0);

    // Starvation: CPU streams, debug raised simultaneously
    bus.cpu_req = 1'b1;
    bus.cpu_address = 16'hC000;
    bus.dbg_req = 1'b1;
    bus.dbg_address = 16'hFFFB;
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stv_cpu_win", bus.rom_select_firmware, 1);
      chk("stv_rom_addr", bus.rom_address, 14'(i));
      chk("stv_cpu_ready", bus.cpu_ready, (i == 7) ? 0 : 1);
      chk("stv_valid", bus.cpu_valid, (i >= 1) ? 1 : 0);
      if (bus.cpu_valid) begin
        n_valid++;
        chk("stv_data", bus.cpu_data, 8'(i - 1) ^ 8'h5A);
      end
      bus.cpu_address = 16'hC000 + 16'(i + 1);
    end
    step();
    chk("stv_dbg_grant", bus.rom_select_vectors, 1);
    chk("stv_dbg_rom_addr", bus.rom_address, 14'h3FFB);
    chk("stv_ready_back", bus.cpu_ready, 1);
    chk("stv_last_valid", bus.cpu_valid, 1);
    chk("stv_last_data", bus.cpu_data, 8'h5D);
    if (bus.cpu_valid) n_valid++;
    step();
    chk("stv_stalled_served", bus.rom_address, 14'h0008);
    chk("stv_dbg_ack", bus.dbg_ack, 1);
    chk("stv_dbg_data", bus.dbg_data, 8'hA1);
    chk("stv_cpu_results", n_valid, 8);
    chk("stv_no_cpu_valid", bus.cpu_valid, 0);
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    step();
    chk("stv_stalled_valid", bus.cpu_valid, 1);
    chk("stv_stalled_data", bus.cpu_data, 8'h52);
    chk("stv_ready_final", bus.cpu_ready, 1);

    // Misses
    bus.dbg_req = 1'b1;
    bus.dbg_address = 16'h8000;
    step();
    chk("miss_dbg_sel_fw", bus.rom_select_firmware, 0);
    chk("miss_dbg_sel_vec", bus.rom_select_vectors, 0);
    chk("miss_dbg_rom_addr", bus.rom_address, 0);
    step();
    chk("miss_dbg_ack", bus.dbg_ack, 1);
    chk("miss_dbg_error", bus.dbg_error, 1);
    chk("miss_dbg_data", bus.dbg_data, 0);
    bus.dbg_req = 1'b0;
    step();
    bus.cpu_req = 1'b1;
    bus.cpu_address = 16'h1234;
    step();
    chk("miss_cpu_sel_fw", bus.rom_select_firmware, 0);
    chk("miss_cpu_rom_addr", bus.rom_address, 0);
    bus.cpu_req = 1'b0;
    step();
    chk("miss_cpu_valid", bus.cpu_valid, 1);
    chk("miss_cpu_data", bus.cpu_data, 0);
    step();

    // Reset right after a debug grant
    bus.dbg_req = 1'b1;
    bus.dbg_address = 16'hFFFC;
    step();
    chk("rmid_grant", bus.rom_select_vectors, 1);
    rst = 1'b1;
    step();
    chk("rmid_no_ack", bus.dbg_ack, 0);
    chk("rmid_cpu_ready", bus.cpu_ready, 1);
    chk("rmid_sel_vec", bus.rom_select_vectors, 0);
    chk("rmid_rom_addr", bus.rom_address, 0);
    chk("rmid_cpu_data", bus.cpu_data, 0);
    rst = 1'b0;
    step();
    chk("rmid_regrant", bus.rom_select_vectors, 1);
    chk("rmid_rom_addr2", bus.rom_address, 14'h3FFC);
    chk("rmid_ack_early", bus.dbg_ack, 0);
    step();
    chk("rmid_ack", bus.dbg_ack, 1);
    chk("rmid_data", bus.dbg_data, 8'hA6);
    bus.dbg_req = 1'b0;
    step();
    step();

    // Random interleave against a scoreboard; last cycles only drain
    dbg_out  = 1'b0;
    dbg_addr = 16'h0000;
    dbg_wait = 0;
    prev_low = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      cpu_acc      = bus.cpu_req && bus.cpu_ready;
      cpu_acc_addr = bus.cpu_address;
      step();
      chk("rnd_sel_excl", bus.rom_select_firmware && bus.rom_select_vectors, 0);
      chk("rnd_ready_low2", prev_low && !bus.cpu_ready, 0);
      prev_low = !bus.cpu_ready;
      if (bus.cpu_valid) begin
        chk("rnd_cpu_expected", cpu_q.size() != 0, 1);
        if (cpu_q.size() != 0) begin
          e   = cpu_q.pop_front();
          due = due_q.pop_front();
          chk("rnd_cpu_data", bus.cpu_data, e);
          chk("rnd_cpu_latency", c, due);
        end
      end
      if (cpu_acc) begin
        cpu_q.push_back(exp_data(cpu_acc_addr));
        due_q.push_back(c + 1);
      end
      if (bus.dbg_ack) begin
        chk("rnd_dbg_expected", dbg_out, 1);
        if (dbg_out) begin
          chk("rnd_dbg_data", bus.dbg_data, exp_data(dbg_addr));
          chk("rnd_dbg_error", bus.dbg_error, dbg_addr[15:14] != 2'b11);
        end
        dbg_out = 1'b0;
        bus.dbg_req = 1'b0;
      end else if (dbg_out) begin
        dbg_wait++;
        chk("rnd_dbg_wait", dbg_wait <= 20, 1);
        if (dbg_wait > 20) begin
          dbg_out = 1'b0;
          bus.dbg_req = 1'b0;
        end
      end
      if (cpu_acc) begin
        bus.cpu_req = (c < 985) && ($urandom_range(0, 3) != 0);
        bus.cpu_address = rand_addr();
      end else if (!bus.cpu_req && (c < 985) && ($urandom_range(0, 1) == 1)) begin
        bus.cpu_req = 1'b1;
        bus.cpu_address = rand_addr();
      end
      if (!dbg_out && !bus.dbg_ack && (c < 985) && ($urandom_range(0, 5) == 0)) begin
        dbg_addr = rand_addr();
        bus.dbg_address = dbg_addr;
        bus.dbg_req = 1'b1;
        dbg_out = 1'b1;
        dbg_wait = 0;
      end
    end
    chk("rnd_cpu_drained", cpu_q.size(), 0);
    chk("rnd_dbg_drained", dbg_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/firmware_arbiter.md
Name: firmware_arbiter

Overview:
- Shares the single firmware ROM port (14-bit address, 8-bit data, firmware/vector selects) between two requesters: the 6502 CPU bus and a debug readback port (ROM dump over the debug link).
- CPU has priority. The debug port is protected against starvation by a bounded CPU stall using the 6502 RDY line.
- Sits between the CPU bus decoder / debug bridge and the firmware ROM.
- All outputs are registered. Read latency is 2 cycles.

Parameters:
- STARVE_LIMIT, 8: consecutive CPU wins with a debug request pending before the CPU is stalled for one cycle. Legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU read strobe; held with address while cpu_ready=0
- cpu_address  in  16  CPU byte address
- cpu_ready  out  1  RDY to CPU; 0 = request not accepted this cycle
- cpu_valid  out  1  one-cycle pulse; cpu_data valid
- cpu_data  out  8  read data
- dbg_req  in  1  debug read request; level, held until dbg_ack
- dbg_address  in  16  debug byte address
- dbg_ack  out  1  one-cycle pulse; dbg_data/dbg_error valid
- dbg_error  out  1  address outside ROM window (with dbg_ack)
- dbg_data  out  8  read data
- rom_address  out  14  to ROM
- rom_data  in  8  from ROM, combinational w.r.t. rom_address/selects
- rom_select_firmware  out  1  ROM firmware-region select
- rom_select_vectors  out  1  ROM vector-region select

Behaviour:
- Reset values:
  - cpu_ready=1.
  - All other outputs 0, including rom_address and both selects.
  - starve_count=0, dbg_busy=0.
  - Stage registers cleared, so no valid or ack fires from a transaction in flight at reset.
- Address decode (winner's address A):
  - ROM window is A[15:14]=2'b11.
  - A≥0xFFFA: rom_select_vectors=1.
  - 0xC000≤A≤0xFFF9: rom_select_firmware=1.
  - rom_address=A[13:0].
  - Outside the window: both selects 0, rom_address=0, and a miss flag travels with the transaction.
  - The two selects are never both 1.
- dbg_pending = dbg_req && !dbg_busy.
- Stage A (arbitrate, edge E0):
  - If cpu_req && cpu_ready: the CPU wins.
  - Else if dbg_pending: the debug port wins and dbg_busy is set.
  - Else the stage is idle: selects 0, rom_address holds.
  - The winner's decode is registered onto the ROM outputs, together with an owner tag and the miss flag.
- Stage B (capture, edge E1): rom_data is captured into the owner's data register and the owner's strobe is pulsed high for one cycle.
  - CPU owner: cpu_data=rom_data (0x00 on miss), cpu_valid=1.
  - Debug owner: dbg_data=rom_data (0x00 on miss), dbg_error=miss, dbg_ack=1.
  - Strobes are 0 in all other cycles. Data registers hold their value between strobes.
- Latency: a request accepted at E0 gives valid/ack high in the cycle after E1. A back-to-back CPU stream gives one result per cycle.
- dbg_busy:
  - Set at grant.
  - Cleared at the edge that ends the dbg_ack cycle.
  - dbg_req sampled during the grant-to-ack window, including the ack cycle, is ignored.
  - The requester must drop dbg_req in the cycle after ack, or a new read starts.
- Starvation control:
  - starve_count increments on each edge where the CPU wins while dbg_pending.
  - It resets to 0 on a debug grant, or on any edge where dbg_pending=0.
  - When the incremented value equals STARVE_LIMIT, cpu_ready is registered 0 for the next cycle.
  - In that cycle the debug port wins unconditionally and the count resets.
  - cpu_ready returns to 1 on the following edge.
  - While cpu_ready=0 the CPU holds cpu_req and cpu_address; that request is served on the next cycle.
  - cpu_ready is never low for more than 1 consecutive cycle.
- Debug port only: if cpu_req=0, the debug port is granted without any stall (cpu_ready stays 1).
- Simultaneous first requests: the CPU wins and starve_count becomes 1.
- Reset asserted mid-operation: takes effect at the next edge and overrides all other updates.

Test Plan:
- CPU read, ROM model data = A[7:0]^0x5A: cpu_req with 0xC010 at E0 → rom_select_firmware=1, rom_address=0x0010 after E0; cpu_valid=1, cpu_data=0x4A after E1. Read 0xFFFC → rom_select_vectors=1, rom_address=0x3FFC, cpu_data=0xA6.
- Debug read, CPU idle: dbg_req with 0xFFFA → ack 2 cycles after the request edge, dbg_data=0xA0, dbg_error=0, cpu_ready stays 1. dbg_req held through the ack cycle → no second grant.
- Starvation, STARVE_LIMIT=8: cpu_req held high continuously, dbg_req raised → exactly 8 CPU results, then one cycle with cpu_ready=0, then the debug grant and dbg_ack. The CPU read stalled in that cycle completes next, and cpu_ready is 1 again.
- Miss: dbg_address=0x8000 → both selects 0, dbg_ack=1, dbg_error=1, dbg_data=0x00. cpu_address=0x1234 → cpu_valid=1, cpu_data=0x00.
- Reset mid-operation: rst at the edge after a debug grant → no dbg_ack, all outputs at reset values, cpu_ready=1. The same request afterwards is served normally.
- Random interleave (1000 cycles) against a reference model: every accepted request gets exactly one valid/ack with correct data, cpu_ready is never low 2 cycles in a row, and the selects are never both 1.
